// File: rtl/uart_pkg.sv
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared state encodings, parity codes and helpers for the UART Tx.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int DATA_W = 8;

    // State encodings
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic [2:0] ST_STOP   = 3'd5;
    localparam logic [2:0] ST_BREAK  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_WAIT   = ST_WAIT,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP,
        S_BREAK  = ST_BREAK
    } state_t;

    // ParityType codes
    localparam logic [1:0] PAR_NONE0 = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_NONE3 = 2'b11;

    function automatic logic has_parity(input logic [1:0] ptype);
        return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_frame_serializer.sv
// ============================================================================
//  Module   : uart_tx_frame_serializer
//  Purpose  : Shifts one start/8 data/optional parity/1-2 stop frame on BaudTick.
//             Optional line-break generation when UART_TX_BREAK_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_frame_serializer
    import uart_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              Clock,
    input  logic              ResetN,
    input  logic              BaudTick,
    input  logic              Send,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              ParityIn,
    input  logic [1:0]        ParityType,
    input  logic              StopBits,
`ifdef UART_TX_BREAK_EN
    input  logic              SendBreak,
`endif
    output logic              DataTx,
    output logic              Busy,
    output logic              Done
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              par_q, par_d;
    logic [1:0]        ptype_q, ptype_d;
    logic              stop2_q, stop2_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              tx_q, tx_d;
    logic              done_c;
    logic [2:0]        next_idx;
    logic              accept;

`ifdef UART_TX_BREAK_EN
    logic              brk_q, brk_d;
    logic [3:0]        brk_cnt_q, brk_cnt_d;
    logic [3:0]        brk_last;

    assign accept   = Send | SendBreak;
    // Break holds low for 1+8+P+S ticks; last index is that length minus one.
    assign brk_last = 4'd8 + {3'b000, has_parity(ptype_q)} + {3'b000, stop2_q};
`else
    assign accept   = Send;
`endif

    assign next_idx = cnt_q + 3'd1;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            par_q     <= 1'b0;
            ptype_q   <= PAR_NONE0;
            stop2_q   <= 1'b0;
            cnt_q     <= 3'd0;
            tx_q      <= 1'b1;
`ifdef UART_TX_BREAK_EN
            brk_q     <= 1'b0;
            brk_cnt_q <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            par_q     <= par_d;
            ptype_q   <= ptype_d;
            stop2_q   <= stop2_d;
            cnt_q     <= cnt_d;
            tx_q      <= tx_d;
`ifdef UART_TX_BREAK_EN
            brk_q     <= brk_d;
            brk_cnt_q <= brk_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        par_d     = par_q;
        ptype_d   = ptype_q;
        stop2_d   = stop2_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        done_c    = 1'b0;
`ifdef UART_TX_BREAK_EN
        brk_d     = brk_q;
        brk_cnt_d = brk_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                // A BaudTick in the accept cycle is deliberately ignored.
                if (accept) begin
                    state_d = S_WAIT;
                    data_d  = DataIn;
                    par_d   = ParityIn;
                    ptype_d = ParityType;
                    stop2_d = StopBits;
`ifdef UART_TX_BREAK_EN
                    brk_d   = SendBreak;
`endif
                end
            end
            S_WAIT: begin
                if (BaudTick) begin
                    tx_d    = 1'b0;
                    state_d = S_START;
`ifdef UART_TX_BREAK_EN
                    if (brk_q) begin
                        state_d   = S_BREAK;
                        brk_cnt_d = 4'd0;
                    end
`endif
                end
            end
            S_START: begin
                if (BaudTick) begin
                    state_d = S_DATA;
                    tx_d    = data_q[0];
                    cnt_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (BaudTick) begin
                    if (cnt_q == 3'd7) begin
                        cnt_d = 3'd0;
                        if (has_parity(ptype_q)) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        cnt_d = next_idx;
                        tx_d  = data_q[next_idx];
                    end
                end
            end
            S_PARITY: begin
                if (BaudTick) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                    cnt_d   = 3'd0;
                end
            end
            S_STOP: begin
                if (BaudTick) begin
                    if (stop2_q && (cnt_q == 3'd0)) begin
                        cnt_d = 3'd1;
                    end else begin
                        state_d = S_IDLE;
                        done_c  = 1'b1;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            S_BREAK: begin
                if (BaudTick) begin
                    if (brk_cnt_q == brk_last) begin
                        // Exactly one stop tick follows a break.
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                        cnt_d   = 3'd0;
                        stop2_d = 1'b0;
                    end else begin
                        brk_cnt_d = brk_cnt_q + 4'd1;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign DataTx = tx_q;
    assign Busy   = (state_q != S_IDLE);
    assign Done   = done_c;

endmodule

`default_nettype wire
